// File: rtl/sd_cmd_serial_card.sv
// sd_cmd_serial_card
//   Card-side engine for the SD CMD line. It receives 48-bit host command
//   frames, checks the transmission bit, the end bit and CRC7, and reports good
//   commands as index/argument. On request it drives a 48-bit or 136-bit
//   response after an NCR idle gap.
//
// Ports
//   SD_CLK_IN    SD clock; all logic on the rising edge
//   RST_IN       asynchronous active-high reset
//   cmd_dat_i    sampled CMD line
//   cmd_out_o    CMD output data (1 while released)
//   cmd_oe_o     CMD output enable (1 = drive)
//   CMD_VALID    one-cycle pulse: good command received
//   CMD_ERR      one-cycle pulse: bad frame (CRC, transmission bit or end bit)
//   CMD_INDEX    index of the last good command
//   CMD_ARG      argument of the last good command
//   RSP_REQ      level request to send a response
//   RSP_LONG     1 = 136-bit R2 frame, 0 = 48-bit frame
//   RSP_NOCRC    short frames only: send 7'h7F in the CRC field
//   RSP_IN       response payload
//   RSP_ACK      one-cycle pulse in the cycle after the end bit is driven
//   BUSY         high in every state except IDLE
//   state_dbg_o  current FSM state
//
// Response handshake: RSP_REQ is a level that is sampled only in WAIT_RSP.
// The requester raises it and holds it until RSP_ACK pulses, then drops it.
// A request still high when the engine next reaches WAIT_RSP is accepted as a
// new request; a request seen in any other state is ignored.
module sd_cmd_serial_card #(
  parameter int NCR = 2
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_IN,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  output logic         CMD_VALID,
  output logic         CMD_ERR,
  output logic [5:0]   CMD_INDEX,
  output logic [31:0]  CMD_ARG,
  input  logic         RSP_REQ,
  input  logic         RSP_LONG,
  input  logic         RSP_NOCRC,
  input  logic [127:0] RSP_IN,
  output logic         RSP_ACK,
  output logic         BUSY,
  output logic [2:0]   state_dbg_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX       = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_WAIT_RSP = 3'd3;
  localparam logic [2:0] S_NCR_DLY  = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;

  localparam logic [3:0] NCR_W = 4'(NCR);

  logic [2:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [6:0]   crc_q, crc_d;
  logic [45:0]  rx_sr_q, rx_sr_d;
  logic [3:0]   dly_q, dly_d;
  logic [135:0] tx_sr_q, tx_sr_d;
  logic         tx_long_q, tx_long_d;
  logic         out_q, out_d;
  logic         oe_q, oe_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [5:0]   index_q, index_d;
  logic [31:0]  arg_q, arg_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;

  logic [135:0] rsp_frame;
  logic [39:0]  short_head;
  logic [6:0]   short_crc;
  logic [7:0]   tx_len;
  logic         rx_good;
  logic         rsp_in_unused;

  // CRC7, polynomial x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, bits[i]);
    return c;
  endfunction

  // Long frames send RSP_IN[127:1]; bit 0 is the slot taken by the end bit.
  assign rsp_in_unused = RSP_IN[0];

  // Whole response frame, left-aligned so TX always shifts out bit 135.
  always_comb begin
    short_head = {2'b00, RSP_IN[37:0]};
    short_crc  = RSP_NOCRC ? 7'h7F : crc7_40(short_head);
    if (RSP_LONG) rsp_frame = {2'b00, 6'h3F, RSP_IN[127:1], 1'b1};
    else          rsp_frame = {short_head, short_crc, 1'b1, 88'd0};
  end

  assign tx_len = tx_long_q ? 8'd136 : 8'd48;

  // Evaluated on the edge that samples the end bit (counter 47).
  assign rx_good = rx_sr_q[45] & cmd_dat_i & (rx_sr_q[6:0] == crc_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    rx_sr_d   = rx_sr_q;
    dly_d     = dly_q;
    tx_sr_d   = tx_sr_q;
    tx_long_d = tx_long_q;
    out_d     = out_q;
    oe_d      = oe_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    index_d   = index_q;
    arg_d     = arg_q;
    ack_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_dat_i) begin
          state_d = S_RX;
          cnt_d   = 8'd1;
          crc_d   = crc7_step(7'd0, 1'b0);
        end
      end
      S_RX: begin
        rx_sr_d = {rx_sr_q[44:0], cmd_dat_i};
        if (cnt_q <= 8'd39) crc_d = crc7_step(crc_q, cmd_dat_i);
        if (cnt_q == 8'd47) begin
          state_d = S_CHECK;
          if (rx_good) begin
            valid_d = 1'b1;
            index_d = rx_sr_q[44:39];
            arg_d   = rx_sr_q[38:7];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // valid_q is high exactly when the frame just checked was good.
      S_CHECK: state_d = valid_q ? S_WAIT_RSP : S_IDLE;
      S_WAIT_RSP: begin
        if (RSP_REQ) begin
          tx_sr_d   = rsp_frame;
          tx_long_d = RSP_LONG;
          dly_d     = 4'd0;
          state_d   = S_NCR_DLY;
        end else if (!cmd_dat_i) begin
          state_d = S_RX;
          cnt_d   = 8'd1;
          crc_d   = crc7_step(7'd0, 1'b0);
        end
      end
      S_NCR_DLY: begin
        if (!cmd_dat_i) begin
          state_d = S_RX;
          cnt_d   = 8'd1;
          crc_d   = crc7_step(7'd0, 1'b0);
        end else if (dly_q == NCR_W) begin
          // Start bit goes out on this edge; cnt holds the next bit index.
          state_d = S_TX;
          oe_d    = 1'b1;
          out_d   = tx_sr_q[135];
          tx_sr_d = {tx_sr_q[134:0], 1'b0};
          cnt_d   = 8'd1;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      S_TX: begin
        if (cnt_q == tx_len) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          out_d   = 1'b1;
          ack_d   = 1'b1;
        end else begin
          out_d   = tx_sr_q[135];
          tx_sr_d = {tx_sr_q[134:0], 1'b0};
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      rx_sr_q   <= '0;
      dly_q     <= '0;
      tx_sr_q   <= '0;
      tx_long_q <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      rx_sr_q   <= rx_sr_d;
      dly_q     <= dly_d;
      tx_sr_q   <= tx_sr_d;
      tx_long_q <= tx_long_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      index_q   <= index_d;
      arg_q     <= arg_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_out_o   = out_q;
  assign cmd_oe_o    = oe_q;
  assign CMD_VALID   = valid_q;
  assign CMD_ERR     = err_q;
  assign CMD_INDEX   = index_q;
  assign CMD_ARG     = arg_q;
  assign RSP_ACK     = ack_q;
  assign BUSY        = busy_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sd_cmd_serial_card.sv
module tb_sd_cmd_serial_card;

  localparam int NCR = 2;

  localparam logic [47:0] F_CMD0     = 48'h400000000095;
  localparam logic [47:0] F_CMD8     = 48'h48000001AA87;
  localparam logic [47:0] F_CMD8_ARG = 48'h48000001AB87;
  localparam logic [47:0] F_CMD8_END = 48'h48000001AA86;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_dat_i = 1'b1;
  logic         cmd_out_o, cmd_oe_o, cmd_valid, cmd_err, rsp_ack, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         rsp_req = 1'b0;
  logic         rsp_long = 1'b0;
  logic         rsp_nocrc = 1'b0;
  logic [127:0] rsp_in = '0;
  logic [2:0]   state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  sd_cmd_serial_card #(.NCR(NCR)) dut (
    .SD_CLK_IN  (clk),
    .RST_IN     (rst),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .CMD_VALID  (cmd_valid),
    .CMD_ERR    (cmd_err),
    .CMD_INDEX  (cmd_index),
    .CMD_ARG    (cmd_arg),
    .RSP_REQ    (rsp_req),
    .RSP_LONG   (rsp_long),
    .RSP_NOCRC  (rsp_nocrc),
    .RSP_IN     (rsp_in),
    .RSP_ACK    (rsp_ack),
    .BUSY       (busy),
    .state_dbg_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Drives a 48-bit frame MSB first, one bit per negedge. Returns at the
  // negedge after the end bit was sampled, i.e. the CMD_VALID/CMD_ERR cycle.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_dat_i = f[i];
    end
    @(negedge clk);
    cmd_dat_i = 1'b1;
  endtask

  // Checks the outcome at the return point of send_frame.
  task automatic check_rx(input string name, input logic exp_valid, input logic [5:0] exp_idx,
                          input logic [31:0] exp_arg);
    n_total++;
    if (cmd_valid !== exp_valid) $display("FAIL %s_valid: got %b want %b", name, cmd_valid, exp_valid);
    else n_pass++;
    n_total++;
    if (cmd_err !== ~exp_valid) $display("FAIL %s_err: got %b want %b", name, cmd_err, ~exp_valid);
    else n_pass++;
    n_total++;
    if (cmd_index !== exp_idx) $display("FAIL %s_index: got %h want %h", name, cmd_index, exp_idx);
    else n_pass++;
    n_total++;
    if (cmd_arg !== exp_arg) $display("FAIL %s_arg: got %h want %h", name, cmd_arg, exp_arg);
    else n_pass++;
  endtask

  // Requests a response at the current negedge and collects it from the line.
  task automatic do_response(input string name, input logic [135:0] exp_frame, input int exp_len);
    logic [135:0] got;
    int gap, n;
    logic early_ack;
    rsp_req = 1'b1;
    gap = 0;
    @(negedge clk);
    while (cmd_oe_o !== 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    n_total++;
    if (gap != NCR + 1) $display("FAIL %s_gap: got %0d want %0d", name, gap, NCR + 1);
    else n_pass++;
    got = '0;
    n = 0;
    early_ack = 1'b0;
    while (cmd_oe_o === 1'b1 && n < 200) begin
      got = {got[134:0], cmd_out_o};
      if (rsp_ack !== 1'b0) early_ack = 1'b1;
      n++;
      @(negedge clk);
    end
    rsp_req = 1'b0;
    n_total++;
    if (n != exp_len) $display("FAIL %s_len: got %0d want %0d", name, n, exp_len);
    else n_pass++;
    n_total++;
    if (got !== exp_frame) $display("FAIL %s_frame: got %h want %h", name, got, exp_frame);
    else n_pass++;
    n_total++;
    if (early_ack !== 1'b0) $display("FAIL %s_early_ack: got %b want 0", name, early_ack);
    else n_pass++;
    n_total++;
    if (rsp_ack !== 1'b1 || cmd_out_o !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_end: got ack=%b out=%b busy=%b want 1 1 0", name, rsp_ack, cmd_out_o, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (rsp_ack !== 1'b0) $display("FAIL %s_ack_pulse: got %b want 0", name, rsp_ack);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1 || cmd_valid !== 1'b0 || cmd_err !== 1'b0 ||
        rsp_ack !== 1'b0 || busy !== 1'b0 || state_dbg !== 3'd0)
      $display("FAIL reset_ctrl: got oe=%b out=%b v=%b e=%b ack=%b busy=%b st=%0d want 0 1 0 0 0 0 0",
               cmd_oe_o, cmd_out_o, cmd_valid, cmd_err, rsp_ack, busy, state_dbg);
    else n_pass++;
    n_total++;
    if (cmd_index !== 6'd0 || cmd_arg !== 32'd0)
      $display("FAIL reset_data: got idx=%h arg=%h want 0 0", cmd_index, cmd_arg);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd0();
    send_frame(F_CMD0);
    check_rx("cmd0", 1'b1, 6'd0, 32'd0);
    @(negedge clk);
    n_total++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL cmd0_pulse: got v=%b busy=%b want 0 1", cmd_valid, busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || cmd_oe_o !== 1'b0)
      $display("FAIL cmd0_wait: got busy=%b oe=%b want 1 0", busy, cmd_oe_o);
    else n_pass++;
  endtask

  // Engine is in WAIT_RSP after CMD0; a new frame aborts the pending response.
  task automatic test_abort_wait();
    send_frame(F_CMD8);
    check_rx("abort_wait", 1'b1, 6'd8, 32'h1AA);
    @(negedge clk);
  endtask

  task automatic test_r7_response();
    rsp_long  = 1'b0;
    rsp_nocrc = 1'b0;
    rsp_in    = {90'd0, 6'd8, 32'h1AA};
    do_response("r7", {88'd0, 48'h08000001AA13}, 48);
  endtask

  task automatic test_bad_frame(input string name, input logic [47:0] f);
    logic saw_oe;
    send_frame(f);
    check_rx(name, 1'b0, 6'd8, 32'h1AA);
    rsp_req = 1'b1;
    saw_oe = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_oe_o !== 1'b0) saw_oe = 1'b1;
    end
    n_total++;
    if (saw_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_no_rsp: got oe_seen=%b busy=%b want 0 0", name, saw_oe, busy);
    else n_pass++;
    rsp_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send_frame(F_CMD0);
    check_rx("b2b_a", 1'b1, 6'd0, 32'd0);
    send_frame(F_CMD8);
    check_rx("b2b_b", 1'b1, 6'd8, 32'h1AA);
    send_frame(F_CMD8_END);
    check_rx("b2b_c", 1'b0, 6'd8, 32'h1AA);
    send_frame(F_CMD0);
    check_rx("b2b_d", 1'b1, 6'd0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_long();
    logic [127:0] p;
    p = 128'h0123456789ABCDEF0123456789ABCDEF;
    rsp_long  = 1'b1;
    rsp_nocrc = 1'b0;
    rsp_in    = p;
    do_response("r2", {2'b00, 6'h3F, p[127:1], 1'b1}, 136);
    rsp_long = 1'b0;
  endtask

  task automatic test_abort_ncr();
    send_frame(F_CMD8);
    check_rx("ncr_cmd8", 1'b1, 6'd8, 32'h1AA);
    @(negedge clk);
    rsp_req = 1'b1;
    @(negedge clk);
    rsp_req = 1'b0;
    n_total++;
    if (busy !== 1'b1 || cmd_oe_o !== 1'b0)
      $display("FAIL ncr_dly: got busy=%b oe=%b want 1 0", busy, cmd_oe_o);
    else n_pass++;
    send_frame(F_CMD0);
    check_rx("abort_ncr", 1'b1, 6'd0, 32'd0);
    @(negedge clk);
    n_total++;
    if (cmd_oe_o !== 1'b0 || busy !== 1'b1)
      $display("FAIL abort_ncr_state: got oe=%b busy=%b want 0 1", cmd_oe_o, busy);
    else n_pass++;
  endtask

  task automatic test_nocrc();
    rsp_long  = 1'b0;
    rsp_nocrc = 1'b1;
    rsp_in    = {90'd0, 6'h3F, 32'h80FF8000};
    do_response("r3", {88'd0, 48'h3F80FF8000FF}, 48);
    rsp_nocrc = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    int t;
    send_frame(F_CMD8);
    check_rx("rst_cmd8", 1'b1, 6'd8, 32'h1AA);
    @(negedge clk);
    rsp_in  = {90'd0, 6'd8, 32'h1AA};
    rsp_req = 1'b1;
    t = 0;
    while (cmd_oe_o !== 1'b1 && t < 20) begin
      t++;
      @(negedge clk);
    end
    n_total++;
    if (cmd_oe_o !== 1'b1) $display("FAIL rst_tx_start: got oe=%b want 1", cmd_oe_o);
    else n_pass++;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (cmd_oe_o !== 1'b0 || cmd_out_o !== 1'b1 || busy !== 1'b0 || state_dbg !== 3'd0 ||
        cmd_index !== 6'd0 || cmd_arg !== 32'd0)
      $display("FAIL rst_mid_tx: got oe=%b out=%b busy=%b st=%0d idx=%h arg=%h want 0 1 0 0 0 0",
               cmd_oe_o, cmd_out_o, busy, state_dbg, cmd_index, cmd_arg);
    else n_pass++;
    rsp_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_abort_wait();
    test_r7_response();
    test_bad_frame("bad_arg", F_CMD8_ARG);
    test_bad_frame("bad_end", F_CMD8_END);
    test_back_to_back();
    test_long();
    test_abort_ncr();
    test_nocrc();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
